// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the store-and-forward packet FIFO.
// Optional statistics are enabled by defining SYNC_PKT_FIFO_STATS_EN.
package sync_fifo_pkg;

   // Width of the optional saturating statistics counters
   localparam int STAT_CW = 16;

   // Ceiling log2 used to size the address and pointer fields
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

   // Distance from tailPtr forward to headPtr, modulo 2^ptrWidth
   function automatic logic [31:0] ptrDist(input logic [31:0] headPtr,
                                           input logic [31:0] tailPtr,
                                           input int          ptrWidth);
      logic [31:0] mask;
      mask = (32'd1 << ptrWidth) - 32'd1;
      return (headPtr - tailPtr) & mask;
   endfunction

endpackage

// File: rtl/sync_pkt_fifo_ram.sv
// Word storage for the packet FIFO: one write port, one asynchronous read port.
// Each entry holds {last, data}. Contents are deliberately not reset.
module sync_pkt_fifo_ram #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 8,
   parameter int AW    = 6
) (
   input  logic           CLK,
   input  logic           wrEn_i,
   input  logic [AW-1:0]  wrAddr_i,
   input  logic [WIDTH:0] wrData_i,
   input  logic [AW-1:0]  rdAddr_i,
   output logic [WIDTH:0] rdData_o
);

   logic [WIDTH:0] mem_q [DEPTH];

   // Store the incoming word at the speculative write address
   always_ff @(posedge CLK) begin
      if (wrEn_i) begin
         mem_q[wrAddr_i] <= wrData_i;
      end
   end

   assign rdData_o = mem_q[rdAddr_i];

endmodule

// File: rtl/sync_pkt_fifo.sv
// Single-clock store-and-forward packet FIFO. Words are written speculatively
// and become readable only once the packet's last word commits; bad or
// overflowing packets are rewound and discarded whole.
// Define SYNC_PKT_FIFO_STATS_EN to add saturating drop/commit counters.
module sync_pkt_fifo
   import sync_fifo_pkg::*;
#(
   parameter int   DEPTH                  = 64,
   parameter int   WIDTH                  = 8,
   parameter int   ALMOST_FULL_THRESHOLD  = 4,
   parameter int   ALMOST_EMPTY_THRESHOLD = 0,
   parameter int   FWFT                   = 1,
   localparam int  AW                     = clog2(DEPTH),
   localparam int  CW                     = AW + 1
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               WR_EN,
   input  logic [WIDTH-1:0]   DIN,
   input  logic               WR_LAST,
   input  logic               WR_ERR,
   output logic               FULL,
   output logic               ALMOST_FULL,
   output logic               DROP,
   input  logic               RD_EN,
   output logic [WIDTH-1:0]   DOUT,
   output logic               DOUT_LAST,
   output logic               EMPTY,
   output logic               ALMOST_EMPTY,
   output logic [CW-1:0]      DATA_CNT,
   output logic [CW-1:0]      PKT_CNT
`ifdef SYNC_PKT_FIFO_STATS_EN
   ,
   output logic [STAT_CW-1:0] STAT_DROP_CNT,
   output logic [STAT_CW-1:0] STAT_PKT_CNT
`endif
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_C   = CW'(1);

   logic [CW-1:0]  wrPtr_q, wrPtr_d;
   logic [CW-1:0]  cmtPtr_q, cmtPtr_d;
   logic [CW-1:0]  rdPtr_q, rdPtr_d;
   logic [CW-1:0]  pktCnt_q, pktCnt_d;
   logic           poison_q, poison_d;
   logic           drop_q, drop_d;

   logic [CW-1:0]  occupied;
   logic [CW-1:0]  readable;
   logic [CW-1:0]  freeSlots;
   logic           full;
   logic           empty;
   logic           wrAccept;
   logic           wrDiscard;
   logic           commit;
   logic           rdAccept;
   logic           lastRead;
   logic [WIDTH:0] rdWord;

   assign occupied  = CW'(ptrDist(32'(wrPtr_q), 32'(rdPtr_q), CW));
   assign readable  = CW'(ptrDist(32'(cmtPtr_q), 32'(rdPtr_q), CW));
   assign freeSlots = DEPTH_C - occupied;
   assign full      = (occupied == DEPTH_C);
   assign empty     = (readable == '0);

   // A write is stored only with room and no poisoned packet in progress;
   // otherwise the word is thrown away.
   assign wrAccept  = WR_EN & ~full & ~poison_q;
   assign wrDiscard = WR_EN & (full | poison_q);
   assign commit    = wrAccept & WR_LAST & ~WR_ERR;
   assign rdAccept  = RD_EN & ~empty;
   assign lastRead  = rdAccept & rdWord[WIDTH];

   sync_pkt_fifo_ram #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH),
      .AW    (AW)
   ) uRam (
      .CLK      (CLK),
      .wrEn_i   (wrAccept),
      .wrAddr_i (wrPtr_q[AW-1:0]),
      .wrData_i ({WR_LAST, DIN}),
      .rdAddr_i (rdPtr_q[AW-1:0]),
      .rdData_o (rdWord)
   );

   // Pointer, poison, drop and packet-count next-state logic
   always_comb begin
      wrPtr_d  = wrPtr_q;
      cmtPtr_d = cmtPtr_q;
      rdPtr_d  = rdPtr_q;
      poison_d = poison_q;
      drop_d   = 1'b0;
      pktCnt_d = pktCnt_q;

      if (wrAccept) begin
         wrPtr_d = wrPtr_q + ONE_C;
         if (WR_LAST) begin
            if (WR_ERR) begin
               wrPtr_d = cmtPtr_q;
               drop_d  = 1'b1;
            end else begin
               cmtPtr_d = wrPtr_q + ONE_C;
            end
         end
      end else if (wrDiscard) begin
         poison_d = ~WR_LAST;
         if (WR_LAST) begin
            wrPtr_d = cmtPtr_q;
            drop_d  = 1'b1;
         end
      end

      if (rdAccept) begin
         rdPtr_d = rdPtr_q + ONE_C;
      end

      case ({commit, lastRead})
         2'b10:   pktCnt_d = pktCnt_q + ONE_C;
         2'b01:   pktCnt_d = pktCnt_q - ONE_C;
         default: pktCnt_d = pktCnt_q;
      endcase
   end

   // Register pointers and control state; reset discards everything queued
   always_ff @(posedge CLK) begin
      if (RST) begin
         wrPtr_q  <= '0;
         cmtPtr_q <= '0;
         rdPtr_q  <= '0;
         pktCnt_q <= '0;
         poison_q <= 1'b0;
         drop_q   <= 1'b0;
      end else begin
         wrPtr_q  <= wrPtr_d;
         cmtPtr_q <= cmtPtr_d;
         rdPtr_q  <= rdPtr_d;
         pktCnt_q <= pktCnt_d;
         poison_q <= poison_d;
         drop_q   <= drop_d;
      end
   end

   assign FULL         = full;
   assign EMPTY        = empty;
   assign ALMOST_FULL  = (32'(freeSlots) <= $unsigned(ALMOST_FULL_THRESHOLD));
   assign ALMOST_EMPTY = (32'(readable) <= $unsigned(ALMOST_EMPTY_THRESHOLD));
   assign DROP         = drop_q;
   assign DATA_CNT     = occupied;
   assign PKT_CNT      = pktCnt_q;

   generate
      if (FWFT != 0) begin : gFwft
         // Head word shown directly; forced to zero while nothing is readable
         assign DOUT      = empty ? '0 : rdWord[WIDTH-1:0];
         assign DOUT_LAST = ~empty & rdWord[WIDTH];
      end else begin : gStd
         logic [WIDTH-1:0] dout_q, dout_d;
         logic             doutLast_q, doutLast_d;

         // Capture the head word on an accepted read, hold otherwise
         always_comb begin
            dout_d     = dout_q;
            doutLast_d = doutLast_q;
            if (rdAccept) begin
               dout_d     = rdWord[WIDTH-1:0];
               doutLast_d = rdWord[WIDTH];
            end
         end

         // Output data register
         always_ff @(posedge CLK) begin
            if (RST) begin
               dout_q     <= '0;
               doutLast_q <= 1'b0;
            end else begin
               dout_q     <= dout_d;
               doutLast_q <= doutLast_d;
            end
         end

         assign DOUT      = dout_q;
         assign DOUT_LAST = doutLast_q;
      end
   endgenerate

`ifdef SYNC_PKT_FIFO_STATS_EN
   logic [STAT_CW-1:0] statDrop_q, statDrop_d;
   logic [STAT_CW-1:0] statPkt_q, statPkt_d;

   // Saturating counts of discarded and committed packets
   always_comb begin
      statDrop_d = statDrop_q;
      statPkt_d  = statPkt_q;
      if (drop_d && (statDrop_q != '1)) begin
         statDrop_d = statDrop_q + STAT_CW'(1);
      end
      if (commit && (statPkt_q != '1)) begin
         statPkt_d = statPkt_q + STAT_CW'(1);
      end
   end

   // Statistics registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         statDrop_q <= '0;
         statPkt_q  <= '0;
      end else begin
         statDrop_q <= statDrop_d;
         statPkt_q  <= statPkt_d;
      end
   end

   assign STAT_DROP_CNT = statDrop_q;
   assign STAT_PKT_CNT  = statPkt_q;
`endif

endmodule

// File: tb/tb_sync_pkt_fifo.sv
// Self-checking bench for sync_pkt_fifo (DEPTH=8): directed vectors, corner
// sequences, an FWFT=0 instance, and randomized traffic against a queue model.
// Stats ports are connected when SYNC_PKT_FIFO_STATS_EN is defined.
module tb_sync_pkt_fifo;

   localparam int DEPTH = 8;
   localparam int WIDTH = 8;
   localparam int CW    = 4;

   logic             CLK = 1'b0;
   logic             RST = 1'b1;

   logic             wrEn = 1'b0, wrLast = 1'b0, wrErr = 1'b0, rdEn = 1'b0;
   logic [WIDTH-1:0] din = '0;
   logic             full, almostFull, drop, empty, almostEmpty, doutLast;
   logic [WIDTH-1:0] dout;
   logic [CW-1:0]    dataCnt, pktCnt;

   logic             sWrEn = 1'b0, sWrLast = 1'b0, sWrErr = 1'b0, sRdEn = 1'b0;
   logic [WIDTH-1:0] sDin = '0;
   logic             sFull, sAlmostFull, sDrop, sEmpty, sAlmostEmpty, sDoutLast;
   logic [WIDTH-1:0] sDout;
   logic [CW-1:0]    sDataCnt, sPktCnt;

`ifdef SYNC_PKT_FIFO_STATS_EN
   logic [15:0] statDrop, statPkt, sStatDrop, sStatPkt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   sync_pkt_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(1)) dut (
      .CLK(CLK), .RST(RST), .WR_EN(wrEn), .DIN(din), .WR_LAST(wrLast),
      .WR_ERR(wrErr), .FULL(full), .ALMOST_FULL(almostFull), .DROP(drop),
      .RD_EN(rdEn), .DOUT(dout), .DOUT_LAST(doutLast), .EMPTY(empty),
      .ALMOST_EMPTY(almostEmpty), .DATA_CNT(dataCnt), .PKT_CNT(pktCnt)
`ifdef SYNC_PKT_FIFO_STATS_EN
      , .STAT_DROP_CNT(statDrop), .STAT_PKT_CNT(statPkt)
`endif
   );

   sync_pkt_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(0)) dutStd (
      .CLK(CLK), .RST(RST), .WR_EN(sWrEn), .DIN(sDin), .WR_LAST(sWrLast),
      .WR_ERR(sWrErr), .FULL(sFull), .ALMOST_FULL(sAlmostFull), .DROP(sDrop),
      .RD_EN(sRdEn), .DOUT(sDout), .DOUT_LAST(sDoutLast), .EMPTY(sEmpty),
      .ALMOST_EMPTY(sAlmostEmpty), .DATA_CNT(sDataCnt), .PKT_CNT(sPktCnt)
`ifdef SYNC_PKT_FIFO_STATS_EN
      , .STAT_DROP_CNT(sStatDrop), .STAT_PKT_CNT(sStatPkt)
`endif
   );

   typedef struct {
      logic       wr;
      logic [7:0] d;
      logic       last;
      logic       err;
      logic       rd;
      logic       expEmpty;
      logic [3:0] expData;
      logic [3:0] expPkt;
      logic       expDrop;
      logic [7:0] expDout;
      logic       expLast;
   } vec_t;

   vec_t vecs[14];

   // Reference model: committed words, words of the packet being written
   logic [8:0] cq[$];
   logic [8:0] sq[$];
   logic       mPoison;
   logic       mDrop;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic applyStimulus(input logic w, input logic [7:0] d,
                                input logic l, input logic e, input logic r);
      wrEn = w; din = d; wrLast = l; wrErr = e; rdEn = r;
      step();
      wrEn = 1'b0; wrLast = 1'b0; wrErr = 1'b0; rdEn = 1'b0;
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, " empty"}, 32'(empty), 32'd1);
      checkOutput({tag, " almostEmpty"}, 32'(almostEmpty), 32'd1);
      checkOutput({tag, " full"}, 32'(full), 32'd0);
      checkOutput({tag, " almostFull"}, 32'(almostFull), 32'd0);
      checkOutput({tag, " drop"}, 32'(drop), 32'd0);
      checkOutput({tag, " dataCnt"}, 32'(dataCnt), 32'd0);
      checkOutput({tag, " pktCnt"}, 32'(pktCnt), 32'd0);
      checkOutput({tag, " dout"}, 32'(dout), 32'd0);
      checkOutput({tag, " doutLast"}, 32'(doutLast), 32'd0);
   endtask

   // Advance the model by one clock using pre-edge state
   task automatic modelStep(input logic w, input logic [7:0] d,
                            input logic l, input logic e, input logic r);
      bit isFull;
      isFull = ((cq.size() + sq.size()) == DEPTH);
      mDrop  = 1'b0;
      if (r && cq.size() != 0) begin
         void'(cq.pop_front());
      end
      if (w) begin
         if (mPoison || isFull) begin
            mPoison = !l;
            if (l) begin
               sq.delete();
               mDrop = 1'b1;
            end
         end else begin
            sq.push_back({l, d});
            if (l) begin
               if (e) begin
                  mDrop = 1'b1;
               end else begin
                  foreach (sq[i]) cq.push_back(sq[i]);
               end
               sq.delete();
            end
         end
      end
   endtask

   task automatic checkAgainstModel();
      int occ;
      int pk;
      occ = cq.size() + sq.size();
      pk  = 0;
      foreach (cq[i]) if (cq[i][8]) pk++;
      checkOutput("rnd empty", 32'(empty), 32'(cq.size() == 0));
      checkOutput("rnd full", 32'(full), 32'(occ == DEPTH));
      checkOutput("rnd almostFull", 32'(almostFull), 32'((DEPTH - occ) <= 4));
      checkOutput("rnd almostEmpty", 32'(almostEmpty), 32'(cq.size() == 0));
      checkOutput("rnd dataCnt", 32'(dataCnt), 32'(occ));
      checkOutput("rnd pktCnt", 32'(pktCnt), 32'(pk));
      checkOutput("rnd drop", 32'(drop), 32'(mDrop));
      if (cq.size() != 0) begin
         checkOutput("rnd dout", 32'(dout), 32'(cq[0][7:0]));
         checkOutput("rnd doutLast", 32'(doutLast), 32'(cq[0][8]));
      end else begin
         checkOutput("rnd dout idle", 32'(dout), 32'd0);
      end
   endtask

   initial begin
      // wr d last err rd | empty data pkt drop dout last
      vecs[0]  = '{1'b1, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0, 1'b0, 8'h00, 1'b0};
      vecs[1]  = '{1'b1, 8'h0B, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd0, 1'b0, 8'h00, 1'b0};
      vecs[2]  = '{1'b1, 8'h0C, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 4'd1, 1'b0, 8'h0A, 1'b0};
      vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 4'd1, 1'b0, 8'h0B, 1'b0};
      vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd1, 1'b0, 8'h0C, 1'b1};
      vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 8'h00, 1'b0};
      vecs[6]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0, 1'b0, 8'h00, 1'b0};
      vecs[7]  = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd0, 1'b0, 8'h00, 1'b0};
      vecs[8]  = '{1'b1, 8'h13, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 4'd0, 1'b0, 8'h00, 1'b0};
      vecs[9]  = '{1'b1, 8'h14, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 8'h00, 1'b0};
      vecs[10] = '{1'b1, 8'h21, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0, 1'b0, 8'h00, 1'b0};
      vecs[11] = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 4'd1, 1'b0, 8'h21, 1'b0};
      vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd1, 1'b0, 8'h22, 1'b1};
      vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 8'h00, 1'b0};

      RST = 1'b1;
      step();
      step();
      RST = 1'b0;
      checkReset("reset");

      // Directed vectors: basic packet, then bad packet followed by good one
      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i].wr, vecs[i].d, vecs[i].last, vecs[i].err, vecs[i].rd);
         checkOutput($sformatf("vec%0d empty", i), 32'(empty), 32'(vecs[i].expEmpty));
         checkOutput($sformatf("vec%0d dataCnt", i), 32'(dataCnt), 32'(vecs[i].expData));
         checkOutput($sformatf("vec%0d pktCnt", i), 32'(pktCnt), 32'(vecs[i].expPkt));
         checkOutput($sformatf("vec%0d drop", i), 32'(drop), 32'(vecs[i].expDrop));
         checkOutput($sformatf("vec%0d dout", i), 32'(dout), 32'(vecs[i].expDout));
         checkOutput($sformatf("vec%0d doutLast", i), 32'(doutLast), 32'(vecs[i].expLast));
      end
`ifdef SYNC_PKT_FIFO_STATS_EN
      checkOutput("stat drop", 32'(statDrop), 32'd1);
      checkOutput("stat pkt", 32'(statPkt), 32'd2);
`endif

      // Overflow: 6 committed words, then a 4-word packet hits FULL
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 8'(8'h30 + i), (i == 5), 1'b0, 1'b0);
      end
      checkOutput("ovf dataCnt6", 32'(dataCnt), 32'd6);
      checkOutput("ovf pktCnt", 32'(pktCnt), 32'd1);
      checkOutput("ovf almostFull", 32'(almostFull), 32'd1);
      checkOutput("ovf almostEmpty", 32'(almostEmpty), 32'd0);
      checkOutput("ovf full early", 32'(full), 32'd0);
      applyStimulus(1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
      checkOutput("ovf full", 32'(full), 32'd1);
      checkOutput("ovf dataCnt8", 32'(dataCnt), 32'd8);
      applyStimulus(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
      checkOutput("ovf lost full", 32'(full), 32'd1);
      checkOutput("ovf lost drop", 32'(drop), 32'd0);
      applyStimulus(1'b1, 8'h43, 1'b1, 1'b0, 1'b0);
      checkOutput("ovf drop", 32'(drop), 32'd1);
      checkOutput("ovf rewind dataCnt", 32'(dataCnt), 32'd6);
      checkOutput("ovf rewind full", 32'(full), 32'd0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      checkOutput("ovf drop pulse", 32'(drop), 32'd0);
      for (int i = 0; i < 6; i++) begin
         checkOutput($sformatf("ovf rd%0d dout", i), 32'(dout), 32'(8'h30 + i));
         checkOutput($sformatf("ovf rd%0d last", i), 32'(doutLast), 32'(i == 5));
         applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      end
      checkOutput("ovf end empty", 32'(empty), 32'd1);
      checkOutput("ovf end pktCnt", 32'(pktCnt), 32'd0);

      // Wrap-around: single-word packets read back immediately
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, 8'(8'h80 + i), 1'b1, 1'b0, 1'b0);
         checkOutput($sformatf("wrap%0d pktCnt", i), 32'(pktCnt), 32'd1);
         checkOutput($sformatf("wrap%0d dout", i), 32'(dout), 32'(8'h80 + i));
         checkOutput($sformatf("wrap%0d full", i), 32'(full), 32'd0);
         applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
         checkOutput($sformatf("wrap%0d empty", i), 32'(empty), 32'd1);
         checkOutput($sformatf("wrap%0d pktCnt0", i), 32'(pktCnt), 32'd0);
      end

      // Commit of packet 2 coincides with last-word read of packet 1
      applyStimulus(1'b1, 8'h51, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h52, 1'b1, 1'b0, 1'b0);
      checkOutput("sim pkt1", 32'(pktCnt), 32'd1);
      applyStimulus(1'b1, 8'h61, 1'b0, 1'b0, 1'b1);
      checkOutput("sim dout52", 32'(dout), 32'h52);
      applyStimulus(1'b1, 8'h62, 1'b1, 1'b0, 1'b1);
      checkOutput("sim pktCnt", 32'(pktCnt), 32'd1);
      checkOutput("sim dout61", 32'(dout), 32'h61);
      checkOutput("sim dataCnt", 32'(dataCnt), 32'd2);
      applyStimulus(1'b1, 8'h71, 1'b0, 1'b0, 1'b0);
      checkOutput("mid dataCnt", 32'(dataCnt), 32'd3);
      RST = 1'b1;
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      RST = 1'b0;
      checkReset("midrst");

      // Registered-output build: DOUT follows RD_EN by one cycle, then holds
      sWrEn = 1'b1; sDin = 8'h5A; sWrLast = 1'b1;
      step();
      sWrEn = 1'b0; sWrLast = 1'b0; sDin = 8'h00;
      checkOutput("std empty", 32'(sEmpty), 32'd0);
      checkOutput("std dout before", 32'(sDout), 32'd0);
      sRdEn = 1'b1;
      step();
      sRdEn = 1'b0;
      checkOutput("std dout", 32'(sDout), 32'h5A);
      checkOutput("std last", 32'(sDoutLast), 32'd1);
      step();
      checkOutput("std hold", 32'(sDout), 32'h5A);
      checkOutput("std hold empty", 32'(sEmpty), 32'd1);
      sRdEn = 1'b1;
      step();
      sRdEn = 1'b0;
      checkOutput("std hold empty rd", 32'(sDout), 32'h5A);

      // Randomized traffic against the queue model
      RST = 1'b1;
      step();
      RST = 1'b0;
      cq.delete();
      sq.delete();
      mPoison = 1'b0;
      mDrop   = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         int rdPct;
         logic w, l, e, r;
         logic [7:0] d;
         rdPct = (c / 500) % 3 == 0 ? 20 : ((c / 500) % 3 == 1 ? 70 : 95);
         w = ($urandom_range(0, 99) < 60);
         l = ($urandom_range(0, 5) == 0);
         e = ($urandom_range(0, 7) == 0);
         r = ($urandom_range(0, 99) < rdPct);
         d = 8'($urandom_range(0, 255));
         modelStep(w, d, l, e, r);
         applyStimulus(w, d, l, e, r);
         checkAgainstModel();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
